seq_pair_serializer: RTL

- Upstream feeder for seq_detect_01110.
- Accepts parallel words over a valid/ready handshake and buffers them in a small FIFO.
- Shifts each word out MSB-first, two bits per clock, on registered outputs A (first bit of the pair) and B (second bit).
- The A/B pair stream is the {D0,D1},{D2,D3}... pattern the detector consumes. When data runs out, the output reverts to an idle pair.

---
 rtl/seq_pair_serializer.sv | 115 +++++++++++
 1 files changed

// File: rtl/seq_pair_serializer.sv
`default_nettype none
// ============================================================================
// seq_pair_serializer : word FIFO feeding an MSB-first, two-bits-per-clock
//                       shifter that produces the A/B pair stream.
// Revision 1.0
// ============================================================================
module seq_pair_serializer #(
    parameter int   DATA_W     = 8,
    parameter int   FIFO_DEPTH = 4,
    parameter logic IDLE_A     = 1'b0,
    parameter logic IDLE_B     = 1'b0
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              A,
    output logic              B,
    output logic              pair_valid,
    output logic              busy
);

    localparam int              PTR_W    = $clog2(FIFO_DEPTH);
    localparam int              NPAIR    = DATA_W / 2;
    localparam int              PC_W     = (NPAIR > 1) ? $clog2(NPAIR) : 1;
    localparam logic [PTR_W:0]  C_DEPTH  = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [PC_W-1:0] C_LAST   = PC_W'(NPAIR - 1);
    localparam logic [0:0]      C_ST_IDLE  = 1'b0;
    localparam logic [0:0]      C_ST_SHIFT = 1'b1;

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [PTR_W:0]    r_count;
    logic              r_ready_en;
    logic [0:0]        r_state;
    logic [DATA_W-1:0] r_shreg;
    logic [PC_W-1:0]   r_pcnt;

    logic              w_write;
    logic              w_pop;
    logic [DATA_W-1:0] w_head;

    // Ready depends only on registered state, so din_valid never loops back into it.
    assign din_ready = r_ready_en && (r_count < C_DEPTH);
    assign w_write   = din_valid && din_ready;
    assign w_pop     = (r_count != '0) &&
                       ((r_state == C_ST_IDLE) || (r_pcnt == C_LAST));
    assign w_head    = r_mem[r_rptr];
    assign busy      = (r_count != '0) || (r_state == C_ST_SHIFT);

    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem[r_wptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_ready_en <= 1'b0;
        end else begin
            r_ready_en <= 1'b1;
            if (w_write) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_write, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // The popped word drives its first pair on the pop edge; the shift
    // register keeps only the bits still to be sent, aligned to the top.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state    <= C_ST_IDLE;
            r_shreg    <= '0;
            r_pcnt     <= '0;
            A          <= IDLE_A;
            B          <= IDLE_B;
            pair_valid <= 1'b0;
        end else if (w_pop) begin
            r_state    <= C_ST_SHIFT;
            r_shreg    <= w_head << 2;
            r_pcnt     <= '0;
            A          <= w_head[DATA_W-1];
            B          <= w_head[DATA_W-2];
            pair_valid <= 1'b1;
        end else if (r_state == C_ST_SHIFT) begin
            if (r_pcnt == C_LAST) begin
                r_state    <= C_ST_IDLE;
                r_pcnt     <= '0;
                A          <= IDLE_A;
                B          <= IDLE_B;
                pair_valid <= 1'b0;
            end else begin
                r_shreg <= r_shreg << 2;
                r_pcnt  <= r_pcnt + 1'b1;
                A       <= r_shreg[DATA_W-1];
                B       <= r_shreg[DATA_W-2];
            end
        end
    end

endmodule
`default_nettype wire
